dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- DATA_W, 32, data word width in bits; multiple of 8.
- DEPTH, 32400, number of words stored.
- ADDR_W, 32, request word-address width.
- BASE_ADDR, 0, first valid word address.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- req_valid, in, 1, access request present.
- req_ready, out, 1, request accepted when high with req_valid.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, word address.
- req_wdata, in, DATA_W, write data.
- req_be, in, DATA_W/8, byte-lane write enables.
- rsp_valid, out, 1, one-cycle response strobe.
- rsp_rdata, out, DATA_W, read data.
- rsp_err, out, 1, address out of range.
- dump_start, in, 1, start full-memory stream-out.
- dump_busy, out, 1, dump in progress.
- dump_valid, out, 1, dump beat present.
- dump_ready, in, 1, sink accepts dump beat.
- dump_addr, out, $clog2(DEPTH), word index of the current beat.
- dump_data, out, DATA_W, word contents of the current beat.

Function
REQ-003 The block SHALL implement FSM states IDLE, DUMP_FILL and DUMP_STREAM.
REQ-004 req_ready SHALL equal 1 exactly when the state is IDLE.
REQ-005 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-006 A request SHALL be in range iff BASE_ADDR <= req_addr <= BASE_ADDR+DEPTH-1; the word index SHALL be req_addr-BASE_ADDR.
REQ-007 An accepted in-range write SHALL update only the byte lanes whose req_be bit is 1, on the accept edge.
REQ-008 An accepted read SHALL assert rsp_valid for exactly one cycle, on the edge after accept, with rsp_rdata equal to the word contents and rsp_err=0.
REQ-009 An accepted write SHALL assert rsp_valid for one cycle, on the edge after accept, with rsp_rdata=0.
REQ-010 An out-of-range access SHALL leave memory unmodified and respond after the same one-cycle latency with rsp_rdata=0 and rsp_err=1.
REQ-011 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-012 dump_start in IDLE SHALL move the FSM to DUMP_FILL on the next edge; a request accepted on that same edge SHALL still complete normally.
REQ-013 DUMP_FILL SHALL issue a synchronous read of index 0 and move to DUMP_STREAM one cycle later, so that dump_valid first rises 2 cycles after dump_start is sampled.
REQ-014 In DUMP_STREAM, a beat SHALL be accepted when dump_valid and dump_ready are both 1, and the block SHALL then present index+1 on the next cycle with no bubble.
REQ-015 While dump_ready=0, dump_addr and dump_data SHALL hold stable.
REQ-016 After the beat at index DEPTH-1 is accepted, the FSM SHALL return to IDLE on the same edge, and dump_valid and dump_busy SHALL fall.
REQ-017 dump_busy SHALL be 1 exactly in DUMP_FILL and DUMP_STREAM.
REQ-018 dump_start SHALL be ignored while dump_busy=1.
REQ-019 While dump_busy=1, req_ready SHALL be 0, so no memory write can race the dump.

Reset
REQ-020 While reset is asserted, state SHALL be IDLE, and rsp_valid, rsp_err, dump_valid and dump_busy SHALL be 0.
REQ-021 While reset is asserted, rsp_rdata, dump_data and dump_addr SHALL be 0.
REQ-022 Reset mid-dump SHALL abort the dump immediately.
REQ-023 Memory contents SHALL NOT be cleared by reset.
REQ-024 A request accepted on the edge where reset deasserts SHALL be served normally.

Structure
REQ-025 Package dmem_pkg SHALL hold the FSM state enum and the default DATA_W/DEPTH/ADDR_W constants.
REQ-026 Storage SHALL be a sub-module dmem_bank: single-port, synchronous-read RAM with byte enables, parameterised on DATA_W and DEPTH.
REQ-027 dmem_ctrl SHALL contain only control logic, range check and dump sequencing.

Verification
REQ-028 Write 0xDEADBEEF to addr 5 with be=1111, then read addr 5 -> rsp_valid one cycle after each accept; read returns 0xDEADBEEF, rsp_err=0.
REQ-029 Write 0x000000AA to addr 5 with be=0001 over 0xDEADBEEF -> subsequent read of addr 5 returns 0xDEADBEAA.
REQ-030 Read addr 32400, then write addr 40000 (DEPTH=32400, BASE_ADDR=0) -> rsp_err=1 and rsp_rdata=0 for both; memory unchanged.
REQ-031 Preload addr i = i, pulse dump_start, hold dump_ready=1 -> dump_valid rises 2 cycles later; DEPTH consecutive beats with dump_data=dump_addr; then IDLE and req_ready=1.
REQ-032 Dump with dump_ready toggled every 3 cycles and reset asserted at beat 100 -> data holds stable while stalled; after reset dump_busy=0 and req_ready=1; addr 50 still reads 50.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the data-memory controller.
package dmem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 32400;
    localparam int unsigned ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DUMP_FILL   = 2'd1,
        DUMP_STREAM = 2'd2
    } state_t;

    // Request accepted last edge whose response goes out on the next edge.
    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } pend_t;

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous-read RAM with byte-lane write enables.
module dmem_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32400
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      be,
    output logic [DATA_W-1:0]        rdata
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Storage is never reset so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: request/response access plus full-memory stream-out.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned       DATA_W    = DATA_W_DEF,
    parameter int unsigned       DEPTH     = DEPTH_DEF,
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/8-1:0]      req_be,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    input  logic                     dump_start,
    output logic                     dump_busy,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [$clog2(DEPTH)-1:0] dump_addr,
    output logic [DATA_W-1:0]        dump_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t              state_q, state_d;
    pend_t               pend_q, pend_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [IDX_W-1:0]    dump_addr_q, dump_addr_d;
    logic                dump_valid_q, dump_valid_d;
    logic                dump_busy_q, dump_busy_d;
    logic                req_ready_q, req_ready_d;

    logic                ram_en;
    logic                ram_we;
    logic [IDX_W-1:0]    ram_addr;
    logic [DATA_W-1:0]   ram_rdata;

    logic [ADDR_W-1:0]   req_off;
    logic                in_range;
    logic [IDX_W-1:0]    req_idx;

    assign req_off  = req_addr - BASE_ADDR;
    assign in_range = (req_addr >= BASE_ADDR) && (req_off <= ADDR_W'(DEPTH - 1));
    assign req_idx  = IDX_W'(req_off);

    // RAM port is owned by requests in IDLE and by the dump sequencer otherwise.
    always_comb begin
        state_d     = state_q;
        pend_d      = '0;
        dump_addr_d = dump_addr_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = req_idx;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ram_en = in_range;
                    ram_we = req_we;
                    pend_d = '{valid: 1'b1, we: req_we, err: !in_range};
                end
                if (dump_start) begin
                    state_d     = DUMP_FILL;
                    dump_addr_d = '0;
                end
            end
            DUMP_FILL: begin
                ram_en   = 1'b1;
                ram_addr = '0;
                state_d  = DUMP_STREAM;
            end
            DUMP_STREAM: begin
                if (dump_ready) begin
                    if (dump_addr_q == IDX_W'(DEPTH - 1)) begin
                        state_d = IDLE;
                    end else begin
                        dump_addr_d = dump_addr_q + IDX_W'(1);
                        ram_en      = 1'b1;
                        ram_addr    = dump_addr_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d  = pend_q.valid;
        rsp_err_d    = pend_q.valid && pend_q.err;
        rsp_rdata_d  = (pend_q.valid && !pend_q.we && !pend_q.err) ? ram_rdata : '0;
        req_ready_d  = (state_d == IDLE);
        dump_busy_d  = (state_d != IDLE);
        dump_valid_d = (state_d == DUMP_STREAM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            dump_addr_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            dump_addr_q  <= dump_addr_d;
            dump_valid_q <= dump_valid_d;
            dump_busy_q  <= dump_busy_d;
            req_ready_q  <= req_ready_d;
        end
    end

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (ram_rdata)
    );

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign dump_busy  = dump_busy_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = ram_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed vector bench for dmem_ctrl: request path, range errors and dump streaming.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 32400;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dump_start;
    logic        dump_busy;
    logic        dump_valid;
    logic        dump_ready;
    logic [14:0] dump_addr;
    logic [31:0] dump_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    dmem_ctrl #(
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .BASE_ADDR (32'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drive(1'b0, addr, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_rdata"}, rsp_rdata, exp);
        chk({name, "_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        int exp_beat;
        int cyc;
        logic rdy;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;

        vecs[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd5,          32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd5,          32'h000000AA, 4'b0001, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'd5,          32'h0,        4'b0000, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b0, 32'd32400,      32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'd40000,      32'h12345678, 4'b1111, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 32'd5,          32'h0,        4'b0000, 32'hDEADBEAA, 1'b0};
        vecs[7]  = '{1'b1, 32'd32399,      32'h11223344, 4'b1111, 32'h0,        1'b0};
        vecs[8]  = '{1'b1, 32'd32399,      32'hAABBCCDD, 4'b0110, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'd32399,      32'h0,        4'b0000, 32'h11BBCC44, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'h0,        4'b0000, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'd0,          32'h00000000, 4'b1111, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 32'd0,          32'hFFFFFFFF, 4'b1010, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 32'd0,          32'h0,        4'b0000, 32'hFF00FF00, 1'b0};

        // Reset state
        #2;
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_err",    32'(rsp_err),    32'd0);
        chk("rst_rsp_rdata",  rsp_rdata,       32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_busy",  32'(dump_busy),  32'd0);
        chk("rst_dump_data",  dump_data,       32'd0);
        chk("rst_dump_addr",  32'(dump_addr),  32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single-request vectors with latency checks
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be);
            tick();
            req_valid = 1'b0;
            chk($sformatf("vec%0d_early", v), 32'(rsp_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_rdata", v), rsp_rdata, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_err", v), 32'(rsp_err), 32'(vecs[v].exp_err));
            tick();
            chk($sformatf("vec%0d_drop", v), 32'(rsp_valid), 32'd0);
        end

        // Back-to-back write then read of the same word
        drive(1'b1, 32'd7, 32'h0BADF00D, 4'hF);
        tick();
        drive(1'b0, 32'd7, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        chk("raw_wr_valid", 32'(rsp_valid), 32'd1);
        chk("raw_wr_rdata", rsp_rdata, 32'd0);
        tick();
        chk("raw_rd_valid", 32'(rsp_valid), 32'd1);
        chk("raw_rd_rdata", rsp_rdata, 32'h0BADF00D);
        tick();
        chk("raw_drop", 32'(rsp_valid), 32'd0);

        // Request accepted on the edge where reset deasserts
        reset = 1'b1;
        drive(1'b1, 32'd9, 32'h00000099, 4'hF);
        #3;
        reset = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstedge_valid", 32'(rsp_valid), 32'd1);
        chk("rstedge_err", 32'(rsp_err), 32'd0);
        read_chk("rstedge_rd", 32'd9, 32'h00000099);

        // Preload word i with value i
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(1'b1, 32'(i), 32'(i), 4'hF);
            tick();
        end
        req_valid = 1'b0;
        tick();
        tick();

        // Full dump with a request accepted on the dump_start edge
        dump_start = 1'b1;
        drive(1'b0, 32'd3, 32'h0, 4'h0);
        tick();
        dump_start = 1'b0;
        req_valid  = 1'b0;
        dump_ready = 1'b1;
        chk("fill_busy", 32'(dump_busy), 32'd1);
        chk("fill_valid", 32'(dump_valid), 32'd0);
        chk("fill_ready", 32'(req_ready), 32'd0);
        tick();
        chk("fill_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fill_rsp_rdata", rsp_rdata, 32'd3);
        for (int b = 0; b < int'(DEPTH); b++) begin
            if (dump_valid !== 1'b1 || 32'(dump_addr) !== 32'(b) || dump_data !== 32'(b)) begin
                chk($sformatf("dump_v%0d", b), 32'(dump_valid), 32'd1);
                chk($sformatf("dump_a%0d", b), 32'(dump_addr), 32'(b));
                chk($sformatf("dump_d%0d", b), dump_data, 32'(b));
            end else begin
                n_cmp++;
            end
            dump_start = (b == 10);
            tick();
        end
        dump_start = 1'b0;
        chk("dump_end_valid", 32'(dump_valid), 32'd0);
        chk("dump_end_busy", 32'(dump_busy), 32'd0);
        chk("dump_end_ready", 32'(req_ready), 32'd1);
        tick();
        chk("dump_no_restart", 32'(dump_busy), 32'd0);

        // Stalled dump, aborted by reset at beat 100
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        exp_beat = 0;
        cyc = 0;
        while (exp_beat < 100 && cyc < 2000) begin
            if (dump_valid !== 1'b1 || 32'(dump_addr) !== 32'(exp_beat) ||
                dump_data !== 32'(exp_beat)) begin
                chk($sformatf("stall_a_c%0d", cyc), 32'(dump_addr), 32'(exp_beat));
                chk($sformatf("stall_d_c%0d", cyc), dump_data, 32'(exp_beat));
                chk($sformatf("stall_v_c%0d", cyc), 32'(dump_valid), 32'd1);
            end else begin
                n_cmp++;
            end
            rdy = ((cyc / 3) % 2) == 0;
            dump_ready = rdy;
            tick();
            cyc++;
            if (rdy) exp_beat++;
        end
        chk("stall_reached_100", 32'(exp_beat), 32'd100);
        chk("stall_at_100_addr", 32'(dump_addr), 32'd100);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(dump_busy), 32'd0);
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_data", dump_data, 32'd0);
        chk("abort_addr", 32'(dump_addr), 32'd0);
        dump_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(dump_busy), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        read_chk("keep_50", 32'd50, 32'd50);
        read_chk("keep_5", 32'd5, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
